rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Arbitrates the single register-file write port between the in-order WB stage and the long-latency multiply/divide unit's out-of-band result path. Multiply/divide results enter a small FIFO. The FIFO drains into the register file in cycles where WB does not write, and an anti-starvation hold forces a drain after a bounded wait. The block also gives ID a pending-write check, so it can interlock on registers still waiting in the FIFO. It sits between the WB stage and the register file and drives the debug writeback trace.

## Interface
- DEPTH, 2: FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 4: consecutive denied cycles before the FIFO head preempts WB; ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wb_valid  in  1  WB holds a valid instruction
- wb_we  in  1  WB instruction writes a register
- wb_waddr  in  5  WB destination
- wb_wdata  in  32  WB result
- wb_pc  in  32  WB PC
- wb_hold  out  1  WB must not retire this cycle; WB keeps its instruction (ready_go low)
- md_valid  in  1  mul/div result offered
- md_ready  out  1  FIFO can accept
- md_waddr  in  5  mul/div destination
- md_wdata  in  32  mul/div result
- md_pc  in  32  PC of the mul/div instruction
- id_rs, id_rt, id_rd  in  5 each  ID source and destination registers
- id_pending  out  1  ID register collides with a queued or offered mul/div write
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- debug_wb_pc  out  32  PC of the granted write
- debug_wb_rf_wen  out  4  {4{rf_we}}
- debug_wb_rf_wnum  out  5  equals rf_waddr
- debug_wb_rf_wdata  out  32  equals rf_wdata

## Operation
- Request signals:
  - wb_req = wb_valid && wb_we.
  - head_req = FIFO non-empty.
- Starvation counter (starve_cnt, range 0..STARVE_LIMIT):
  - Increments when head_req is set and the head is not granted; saturates at STARVE_LIMIT.
  - Clears when the head is granted or the FIFO is empty.
- wb_hold = head_req && wb_req && (starve_cnt == STARVE_LIMIT).
- Grant, at most one per cycle:
  - WB is granted if wb_req && !wb_hold.
  - Otherwise the head is granted if head_req.
  - Otherwise nothing is granted.
- Outputs by grant:
  - WB granted: rf_* and debug_* carry WB fields, rf_we=1.
  - Head granted: they carry the head entry, rf_we=1, and the head is popped at the clock edge.
  - No grant: rf_we=0, debug_wb_pc=wb_pc, rf_waddr/rf_wdata carry the WB fields.
- Enqueue:
  - md_ready = !full.
  - An entry is accepted when md_valid && md_ready.
  - An entry with md_waddr==0 is accepted but not stored.
- Push and pop in the same cycle are allowed; the count is unchanged.
- There is no same-cycle bypass. An accepted entry is granted no earlier than the next cycle.
- id_pending asserts when any nonzero id_rs, id_rt, or id_rd equals:
  - the waddr of a valid FIFO entry, or
  - md_waddr while md_valid.
  - Checking id_rd prevents a younger WB write from being overwritten by an older drained mul/div result (WAW).
- Pointers wrap modulo DEPTH. The occupancy count is log2(DEPTH)+1 bits.

## Timing
- rf_*, debug_*, wb_hold, md_ready, and id_pending are combinational from registered state and current inputs. The register file samples them at the posedge.
- Minimum latency from mul/div acceptance to register-file write: 1 cycle.
- Maximum wait for the FIFO head while WB writes every cycle: STARVE_LIMIT cycles, then the head is granted.
- With a full FIFO: md_ready=0, and a held md_valid is stable until accepted.
- Reset clears the FIFO, pointers, count, and starve_cnt. Queued contents are discarded.
- Output values with reset asserted: rf_we=0, wb_hold=0, md_ready=1, id_pending depends only on md_valid/md_waddr, debug_wb_rf_wen=0.

## Test plan
- Reset: hold reset 2 cycles with md_valid=1 -> no register write; FIFO empty after release; md_ready=1.
- Idle drain: wb_valid=0; push md (r8, 0x1234) -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234, debug_wb_pc=md_pc; FIFO empty afterward.
- WB priority: push md r9, then WB writes 3 consecutive cycles -> WB writes on all 3; md r9 writes the cycle after WB stops.
- Starvation: STARVE_LIMIT=4; FIFO holds r10 and WB writes every cycle -> after 4 denied cycles, wb_hold=1 for one cycle and r10 is written; WB's instruction retires the following cycle.
- Full/backpressure: DEPTH=2 filled while WB writes and hold is not reached -> md_ready=0; after one pop, md_ready=1 and the third entry is accepted in order.
- Pending: FIFO holds r5 -> id_rs=5 gives id_pending=1; id_rd=5 gives id_pending=1; r0 and r6 give 0; md r0 is accepted and never written.

Source files
------------

// File: rtl/rf_wport_arbiter_if.sv
// Bundle of the WB, mul/div, ID-check, register-file and debug-trace signals
// around the register-file write-port arbiter. The arbiter uses the slave
// modport; the surrounding pipeline (or a bench) uses the master modport.
interface rf_wport_arbiter_if;
    // WB stage
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic        wb_hold;
    // mul/div out-of-band result path
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic [31:0] md_pc;
    // ID interlock check
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_pending;
    // register-file write port
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    // debug writeback trace
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    modport slave (
        input  wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc,
        output wb_hold,
        input  md_valid, md_waddr, md_wdata, md_pc,
        output md_ready,
        input  id_rs, id_rt, id_rd,
        output id_pending,
        output rf_we, rf_waddr, rf_wdata,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport master (
        output wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc,
        input  wb_hold,
        output md_valid, md_waddr, md_wdata, md_pc,
        input  md_ready,
        output id_rs, id_rt, id_rd,
        input  id_pending,
        input  rf_we, rf_waddr, rf_wdata,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. WB owns the port by default; mul/div
// results wait in a small FIFO and drain in cycles WB leaves free. If the
// FIFO head has been denied STARVE_LIMIT cycles in a row, WB is held for one
// cycle so the head can write. ID gets a pending check against every queued
// or currently offered mul/div destination (RAW and WAW interlock).
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    rf_wport_arbiter_if.slave   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } md_entry_t;

    md_entry_t              mem_q [DEPTH];
    logic [DEPTH-1:0]       valid_q,      valid_d;
    logic [PTR_W-1:0]       wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]       count_q,      count_d;
    logic [SC_W-1:0]        starve_cnt_q, starve_cnt_d;

    logic      wb_req;
    logic      head_req;
    logic      full;
    logic      hold;
    logic      grant_wb;
    logic      grant_head;
    logic      ready;
    logic      push;
    logic      pop;
    logic      pending;
    md_entry_t head;

    // A nonzero destination collides if any ID register names it.
    function automatic logic id_hit(input logic [4:0] a, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd);
        return (a != 5'd0) && ((rs == a) || (rt == a) || (rd == a));
    endfunction

    // Request, hold and grant decisions; reset forces an idle, accepting port.
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        wb_req     = bus.wb_valid && bus.wb_we;
        head_req   = !reset && (count_q != '0);
        full       = (count_q == CNT_W'(DEPTH));
        hold       = head_req && wb_req && (starve_cnt_q == SC_W'(STARVE_LIMIT));
        grant_wb   = !reset && wb_req && !hold;
        grant_head = !grant_wb && head_req;
        ready      = reset || !full;
        push       = !reset && bus.md_valid && ready && (bus.md_waddr != 5'd0);
        pop        = grant_head;
        head       = mem_q[rd_ptr_q];
    end

    // Pending-write check against valid FIFO entries and the offered result.
    always_comb begin
        pending = bus.md_valid && id_hit(bus.md_waddr, bus.id_rs, bus.id_rt, bus.id_rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && valid_q[i] &&
                id_hit(mem_q[i].waddr, bus.id_rs, bus.id_rt, bus.id_rd)) begin
                pending = 1'b1;
            end
        end
    end

    // Next-state for FIFO pointers, occupancy, entry valids and starvation count.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        valid_d      = valid_q;
        starve_cnt_d = starve_cnt_q;
        if (reset) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            valid_d      = '0;
            starve_cnt_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
                valid_d[rd_ptr_q] = 1'b0;
            end
            if (push) begin
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                valid_d[wr_ptr_q] = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (!head_req || grant_head) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + SC_W'(1);
            end
        end
    end

    // State registers; reset is folded into the _d logic above.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        count_q      <= count_d;
        valid_q      <= valid_d;
        starve_cnt_q <= starve_cnt_d;
    end

    // FIFO storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; valid_q and count_q decide what is live.
        if (push) begin
            mem_q[wr_ptr_q] <= '{waddr: bus.md_waddr, wdata: bus.md_wdata, pc: bus.md_pc};
        end
    end

    assign bus.wb_hold           = hold;
    assign bus.md_ready          = ready;
    assign bus.id_pending        = pending;
    assign bus.rf_we             = grant_wb || grant_head;
    assign bus.rf_waddr          = grant_head ? head.waddr : bus.wb_waddr;
    assign bus.rf_wdata          = grant_head ? head.wdata : bus.wb_wdata;
    assign bus.debug_wb_pc       = grant_head ? head.pc    : bus.wb_pc;
    assign bus.debug_wb_rf_wen   = {4{bus.rf_we}};
    assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
    assign bus.debug_wb_rf_wdata = bus.rf_wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_LIMIT=4): a table of
// per-cycle input/expected-output records plus hand-written starvation and
// full-FIFO sequences. Inputs change 1 ns after posedge; outputs are sampled
// on the negedge.
module tb_rf_wport_arbiter;

    typedef struct packed {
        logic        rst;
        logic        wb_valid;
        logic        wb_we;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_wdata;
        logic [31:0] wb_pc;
        logic        md_valid;
        logic [4:0]  md_waddr;
        logic [31:0] md_wdata;
        logic [31:0] md_pc;
        logic [4:0]  id_rs;
        logic [4:0]  id_rt;
        logic [4:0]  id_rd;
        logic        e_rf_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pc;
        logic        e_hold;
        logic        e_ready;
        logic        e_pending;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rf_wport_arbiter_if bus();

    rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        v.e_ready = 1'b1;
        return v;
    endfunction

    function automatic vec_t wb(input vec_t vi, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] pc);
        vec_t v;
        v = vi;
        v.wb_valid = 1'b1;
        v.wb_we    = 1'b1;
        v.wb_waddr = a;
        v.wb_wdata = d;
        v.wb_pc    = pc;
        return v;
    endfunction

    function automatic vec_t md(input vec_t vi, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] pc);
        vec_t v;
        v = vi;
        v.md_valid = 1'b1;
        v.md_waddr = a;
        v.md_wdata = d;
        v.md_pc    = pc;
        return v;
    endfunction

    function automatic vec_t wr(input vec_t vi, input logic [4:0] a,
                                input logic [31:0] d, input logic [31:0] pc);
        vec_t v;
        v = vi;
        v.e_rf_we = 1'b1;
        v.e_waddr = a;
        v.e_wdata = d;
        v.e_pc    = pc;
        return v;
    endfunction

    // Drive one cycle, compare every output on the negedge, then advance.
    task automatic step(input vec_t v, input string tag);
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [31:0] ep;
        reset         = v.rst;
        bus.wb_valid  = v.wb_valid;
        bus.wb_we     = v.wb_we;
        bus.wb_waddr  = v.wb_waddr;
        bus.wb_wdata  = v.wb_wdata;
        bus.wb_pc     = v.wb_pc;
        bus.md_valid  = v.md_valid;
        bus.md_waddr  = v.md_waddr;
        bus.md_wdata  = v.md_wdata;
        bus.md_pc     = v.md_pc;
        bus.id_rs     = v.id_rs;
        bus.id_rt     = v.id_rt;
        bus.id_rd     = v.id_rd;
        // With no grant the port still shows the WB fields.
        ea = v.e_rf_we ? v.e_waddr : v.wb_waddr;
        ed = v.e_rf_we ? v.e_wdata : v.wb_wdata;
        ep = v.e_rf_we ? v.e_pc    : v.wb_pc;
        @(negedge clk);
        check({tag, "_rf_we"},      32'(bus.rf_we),             32'(v.e_rf_we));
        check({tag, "_rf_waddr"},   32'(bus.rf_waddr),          32'(ea));
        check({tag, "_rf_wdata"},   bus.rf_wdata,               ed);
        check({tag, "_dbg_pc"},     bus.debug_wb_pc,            ep);
        check({tag, "_dbg_wen"},    32'(bus.debug_wb_rf_wen),   32'({4{v.e_rf_we}}));
        check({tag, "_dbg_wnum"},   32'(bus.debug_wb_rf_wnum),  32'(ea));
        check({tag, "_dbg_wdata"},  bus.debug_wb_rf_wdata,      ed);
        check({tag, "_wb_hold"},    32'(bus.wb_hold),           32'(v.e_hold));
        check({tag, "_md_ready"},   32'(bus.md_ready),          32'(v.e_ready));
        check({tag, "_id_pending"}, 32'(bus.id_pending),        32'(v.e_pending));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vq[$];
        vec_t v;
        checks = 0;
        errors = 0;

        // Reset with an offered mul/div result: no write, md_ready high,
        // id_pending only from the offered destination.
        v = wb(md(idle(), 5'd7, 32'h77, 32'h700), 5'd3, 32'hAAAA, 32'h100);
        v.rst = 1'b1;
        vq.push_back(v);
        v.id_rs = 5'd7; v.e_pending = 1'b1;
        vq.push_back(v);
        // After release: r7 was never queued.
        v = idle(); v.id_rs = 5'd7;
        vq.push_back(v);
        // Idle drain of r8 one cycle after acceptance.
        vq.push_back(md(idle(), 5'd8, 32'h1234, 32'h2000));
        v = wr(idle(), 5'd8, 32'h1234, 32'h2000); v.id_rs = 5'd8; v.e_pending = 1'b1;
        vq.push_back(v);
        v = idle(); v.id_rs = 5'd8;
        vq.push_back(v);
        // WB priority: r9 queued, WB writes three cycles, then r9 drains.
        vq.push_back(md(idle(), 5'd9, 32'h9999, 32'h3000));
        v = wr(wb(idle(), 5'd1, 32'h11, 32'h400), 5'd1, 32'h11, 32'h400);
        v.id_rd = 5'd9; v.e_pending = 1'b1;
        vq.push_back(v);
        vq.push_back(wr(wb(idle(), 5'd2, 32'h22, 32'h404), 5'd2, 32'h22, 32'h404));
        vq.push_back(wr(wb(idle(), 5'd3, 32'h33, 32'h408), 5'd3, 32'h33, 32'h408));
        vq.push_back(wr(idle(), 5'd9, 32'h9999, 32'h3000));
        v = idle(); v.id_rd = 5'd9;
        vq.push_back(v);
        // Pending checks while r5 waits behind WB writes.
        v = md(idle(), 5'd5, 32'h55, 32'h5000); v.id_rs = 5'd5; v.e_pending = 1'b1;
        vq.push_back(v);
        v = wr(wb(idle(), 5'd4, 32'h44, 32'h600), 5'd4, 32'h44, 32'h600);
        v.id_rs = 5'd5; v.e_pending = 1'b1;
        vq.push_back(v);
        v = wr(wb(idle(), 5'd4, 32'h45, 32'h604), 5'd4, 32'h45, 32'h604);
        v.id_rd = 5'd5; v.e_pending = 1'b1;
        vq.push_back(v);
        v = wr(wb(idle(), 5'd4, 32'h46, 32'h608), 5'd4, 32'h46, 32'h608);
        v.id_rt = 5'd6;
        vq.push_back(v);
        // r5 drains while an r0 result is accepted but not stored.
        vq.push_back(wr(md(idle(), 5'd0, 32'hDEAD, 32'h7000), 5'd5, 32'h55, 32'h5000));
        vq.push_back(idle());
        // WB valid without a register write is not a request.
        v = idle(); v.wb_valid = 1'b1; v.wb_waddr = 5'd7; v.wb_wdata = 32'h77; v.wb_pc = 32'hABC;
        vq.push_back(v);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i], $sformatf("t%0d", i));
        end

        // Starvation: r10 waits four denied cycles, then WB is held once.
        step(md(idle(), 5'd10, 32'hA0A0, 32'h8000), "s_push");
        for (int i = 0; i < 4; i++) begin
            v = wb(idle(), 5'd11, 32'hB0 + 32'(i), 32'h900 + 32'(4 * i));
            v = wr(v, 5'd11, 32'hB0 + 32'(i), 32'h900 + 32'(4 * i));
            v.id_rs = 5'd10; v.e_pending = 1'b1;
            step(v, $sformatf("s_deny%0d", i));
        end
        v = wr(wb(idle(), 5'd11, 32'hB4, 32'h910), 5'd10, 32'hA0A0, 32'h8000);
        v.e_hold = 1'b1;
        step(v, "s_hold");
        step(wr(wb(idle(), 5'd11, 32'hB4, 32'h910), 5'd11, 32'hB4, 32'h910), "s_retire");
        step(idle(), "s_idle");

        // Full FIFO: fill while WB writes, back-pressure, drain in order.
        step(wr(md(wb(idle(), 5'd1, 32'hF1, 32'hA00), 5'd12, 32'hC1, 32'hC00),
                5'd1, 32'hF1, 32'hA00), "f_push0");
        step(wr(md(wb(idle(), 5'd1, 32'hF2, 32'hA04), 5'd13, 32'hC2, 32'hC04),
                5'd1, 32'hF2, 32'hA04), "f_push1");
        v = wr(md(wb(idle(), 5'd1, 32'hF3, 32'hA08), 5'd14, 32'hC3, 32'hC08),
               5'd1, 32'hF3, 32'hA08);
        v.e_ready = 1'b0;
        step(v, "f_full");
        v = wr(md(idle(), 5'd14, 32'hC3, 32'hC08), 5'd12, 32'hC1, 32'hC00);
        v.e_ready = 1'b0;
        step(v, "f_pop0");
        step(wr(md(idle(), 5'd14, 32'hC3, 32'hC08), 5'd13, 32'hC2, 32'hC04), "f_pop1");
        step(wr(idle(), 5'd14, 32'hC3, 32'hC08), "f_pop2");
        step(idle(), "f_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
